core_run_ctrl: RTL
==================

Name: core_run_ctrl

Overview:
- Drives the processor core's `start`/`start_addr` control inputs and consumes its `halt` output.
- Launches a fixed list of programs in order and measures each one's run length in cycles.
- Each run ends in one result record: cycle count plus a timeout flag.
- Sits beside the core in the test/run harness; used for batch runs of the assignment programs without a testbench hand-driving `start`.

Parameters:
- NUM_PROGS, 3, number of programs launched per batch (1..8)
- ADDR_W, 9, width of a program start address
- CNT_W, 16, width of the run-length counter
- START_CYCLES, 2, cycles `core_start` is held high per launch (>=1)
- TIMEOUT, 16'hFFFF, run length at which a program is abandoned

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- go  input  1  single-cycle request to run the batch
- prog_base  input  NUM_PROGS*ADDR_W  start addresses; program i at bits [i*ADDR_W +: ADDR_W]
- core_start  output  1  to core `start`
- core_start_addr  output  ADDR_W  to core `start_addr`
- core_halt  input  1  from core `halt`
- busy  output  1  batch in progress
- prog_idx  output  $clog2(NUM_PROGS)+1  index of current/last program
- res_valid  output  1  one-cycle strobe, result fields valid
- res_cycles  output  CNT_W  run length of the finished program
- res_timeout  output  1  program hit TIMEOUT
- done  output  1  one-cycle strobe, batch complete

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset is asynchronous and takes effect mid-batch in any state; the batch is abandoned with no further result.
- State IDLE: busy=0.
  - `go`=1 -> LAUNCH; prog_idx<=0; core_start_addr<=prog_base slice 0.
- State LAUNCH: core_start=1 for exactly START_CYCLES cycles; core_start_addr stable throughout. core_halt is ignored in LAUNCH. Then -> RUN, cycle counter cleared to 0.
- State RUN: core_start=0.
  - Each cycle with core_halt=0: counter += 1.
  - First cycle with core_halt=1: res_cycles<=counter; res_timeout<=0; -> REPORT.
  - If counter == TIMEOUT-1 and core_halt=0: res_cycles<=TIMEOUT; res_timeout<=1; -> REPORT.
  - The counter never wraps.
- State REPORT: res_valid=1 for one cycle; res_cycles and res_timeout hold their values until the next REPORT.
  - If prog_idx == NUM_PROGS-1 -> FINISH.
  - Otherwise prog_idx += 1, core_start_addr <= next slice, -> LAUNCH.
- State FINISH: done=1 for one cycle, busy drops the same cycle, -> IDLE.
- busy=1 in LAUNCH, RUN, REPORT and FINISH.
- `go` while busy is ignored, not queued.
- core_halt already high on the first RUN cycle -> res_cycles=0, no timeout.
- Timing from `go`: core_start first high 1 cycle after `go`; first RUN cycle is 1+START_CYCLES cycles after `go`.
- prog_base is sampled per launch, at the transition into LAUNCH.
- NUM_PROGS=1: one LAUNCH/RUN/REPORT, then FINISH.

Optional Feature:
- Macro RUN_CTRL_ABORT_EN.
- Defined: adds input port `abort` (1 bit).
  - In LAUNCH or RUN, `abort`=1 -> FINISH next cycle, skipping REPORT for the current program.
  - core_start forced 0 that cycle; done still pulses.
  - `abort` in IDLE, REPORT or FINISH has no effect.
- Not defined: the port is absent and the batch always runs to completion.

Test Plan:
- Basic run: NUM_PROGS=3, START_CYCLES=2, bases 0/40/80; core model halts after 10, 25, 7 RUN cycles; pulse `go` -> three res_valid strobes with res_cycles 10, 25, 7; res_timeout=0; core_start_addr 0,40,80 during each 2-cycle start; done strobe after the third REPORT.
- Immediate halt: core_halt tied 1 -> core_halt ignored during LAUNCH; each program reports res_cycles=0; done after 3 reports.
- Timeout: TIMEOUT=20, core never halts -> each program reports res_cycles=20 with res_timeout=1; batch completes.
- `go` re-pulsed during RUN of program 1 -> no effect; exactly 3 results, then a later `go` starts a fresh batch at prog_idx=0.
- Reset asserted mid-RUN of program 1 -> all outputs 0 asynchronously; no res_valid or done afterwards; next `go` runs normally.
- RUN_CTRL_ABORT_EN: `abort` pulse in RUN of program 0 -> no res_valid for program 0; done strobe next cycle; busy=0 after.

Source files
------------

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: batch launcher for the processor core.
// Launches NUM_PROGS programs in order, times each run and emits one result
// record (cycle count + timeout flag) per program, then a done strobe.
// Optional feature macro: RUN_CTRL_ABORT_EN adds an `abort` input that ends the
// batch early from LAUNCH or RUN.
// Strobe semantics: `go` is a single-cycle request that is sampled only in IDLE.
// `res_valid` and `done` are single-cycle strobes with no back-pressure, and
// res_cycles/res_timeout hold their values until the next result.
// dbg_state encoding: 0=IDLE 1=LAUNCH 2=RUN 3=REPORT 4=FINISH.
module core_run_ctrl #(
    parameter int                NUM_PROGS    = 3,
    parameter int                ADDR_W       = 9,
    parameter int                CNT_W        = 16,
    parameter int                START_CYCLES = 2,
    parameter logic [CNT_W-1:0]  TIMEOUT      = 16'hFFFF,
    localparam int               IDX_W        = $clog2(NUM_PROGS) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        go,
`ifdef RUN_CTRL_ABORT_EN
    input  logic                        abort,
`endif
    input  logic [NUM_PROGS*ADDR_W-1:0] prog_base,
    output logic                        core_start,
    output logic [ADDR_W-1:0]           core_start_addr,
    input  logic                        core_halt,
    output logic                        busy,
    output logic [IDX_W-1:0]            prog_idx,
    output logic                        res_valid,
    output logic [CNT_W-1:0]            res_cycles,
    output logic                        res_timeout,
    output logic                        done,
    output logic [2:0]                  dbg_state
);

    localparam int               SC_W       = $clog2(START_CYCLES + 1);
    localparam logic [SC_W-1:0]  START_LAST = SC_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = TIMEOUT - 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PROGS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_REPORT = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [SC_W-1:0]    scnt_q, scnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   res_cycles_q, res_cycles_d;
    logic               res_timeout_q, res_timeout_d;
    logic               abort_req;

`ifdef RUN_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State and datapath registers; reset abandons any batch in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            addr_q        <= '0;
            scnt_q        <= '0;
            cnt_q         <= '0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            addr_q        <= addr_d;
            scnt_q        <= scnt_d;
            cnt_q         <= cnt_d;
            res_cycles_q  <= res_cycles_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    // Next-state logic, start pulse generation and run-length measurement.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        scnt_d        = scnt_q;
        cnt_d         = cnt_q;
        res_cycles_d  = res_cycles_q;
        res_timeout_d = res_timeout_q;
        core_start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_LAUNCH;
                    idx_d   = '0;
                    addr_d  = prog_base[0 +: ADDR_W];
                    scnt_d  = '0;
                end
            end
            S_LAUNCH: begin
                // core_halt is deliberately not looked at while starting.
                if (abort_req) begin
                    state_d = S_FINISH;
                end else begin
                    core_start = 1'b1;
                    if (scnt_q == START_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Halt wins over timeout; the counter stops at TIMEOUT-1 so it never wraps.
                if (abort_req) begin
                    state_d = S_FINISH;
                end else if (core_halt) begin
                    res_cycles_d  = cnt_q;
                    res_timeout_d = 1'b0;
                    state_d       = S_REPORT;
                end else if (cnt_q == TO_LAST) begin
                    res_cycles_d  = TIMEOUT;
                    res_timeout_d = 1'b1;
                    state_d       = S_REPORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REPORT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    scnt_d  = '0;
                    state_d = S_LAUNCH;
                    // The next start address is sampled on entry to LAUNCH.
                    for (int i = 0; i < NUM_PROGS; i++) begin
                        if (idx_q + IDX_W'(1) == IDX_W'(i)) begin
                            addr_d = prog_base[i*ADDR_W +: ADDR_W];
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from registered state.
    always_comb begin
        busy            = (state_q != S_IDLE);
        res_valid       = (state_q == S_REPORT);
        done            = (state_q == S_FINISH);
        prog_idx        = idx_q;
        core_start_addr = addr_q;
        res_cycles      = res_cycles_q;
        res_timeout     = res_timeout_q;
        dbg_state       = state_q;
    end

endmodule
